match_scoreboard: RTL and testbench
===================================

Name: match_scoreboard

Overview:
- Sits directly downstream of the ball controller and alongside the game controller.
- Consumes the raw score_to_team1 / score_to_team2 goal indications and the ball controller's game_on.
- Keeps per-team goal counts, runs the match clock and the post-goal pause, and decides when the match ends.
- Its game_over output feeds back to the ball controller; its counts and time feed the display path.

Parameters:
- CLK_FREQ, 50000000, clock cycles per match-clock second.
- MATCH_SECONDS, 180, initial time_left value in seconds (max 255).
- WIN_SCORE, 10, goal count that ends the match immediately.
- GOAL_PAUSE_SECONDS, 2, seconds the match clock freezes after a goal (min 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; begins a match from IDLE or OVER.
- game_on  in  1  ball in play, from the ball controller.
- score_to_team1  in  1  level goal indication for team 1 (may stay high several cycles).
- score_to_team2  in  1  level goal indication for team 2.
- team1_goals  out  8  team 1 goal count.
- team2_goals  out  8  team 2 goal count.
- time_left  out  8  seconds remaining.
- game_over  out  1  high in OVER.
- ball_reset  out  1  one-cycle pulse on the cycle the goal pause ends.
- winner  out  2  valid in OVER: 00 none/draw, 01 team 1, 10 team 2.

Behaviour:
- Reset values (cycle after rst sampled high):
  - State IDLE; goals 0/0; time_left = MATCH_SECONDS.
  - game_over 0, ball_reset 0, winner 00.
  - Tick counter 0; edge-detect registers 0.
  - rst overrides every other input, including mid-pause and mid-match.
- Goal detection:
  - Rising-edge detect on each score input, using a registered copy.
  - A goal counts once per rising edge; a held-high input counts once.
  - Edges are ignored outside RUNNING, but the edge registers always update.
- Tick divider:
  - Free counter 0..CLK_FREQ-1.
  - sec_tick asserts for one cycle when the counter equals CLK_FREQ-1, then wraps to 0.
  - The counter advances only in RUNNING (with game_on=1) and in PAUSE; it holds otherwise.
  - The counter clears on entry to RUNNING from IDLE/OVER.
- States:
  - IDLE:
    - start=1 -> RUNNING next cycle.
    - Goals cleared, time_left = MATCH_SECONDS.
  - RUNNING:
    - sec_tick with game_on=1 -> time_left decrements.
    - A goal edge increments the matching count, saturating at 255, and enters PAUSE.
    - Both edges in the same cycle -> both counts increment, single PAUSE entry.
    - Goal edge and sec_tick in the same cycle -> both apply.
    - time_left reaching 0, or any count reaching WIN_SCORE -> OVER next cycle.
    - OVER takes priority over PAUSE.
  - PAUSE:
    - Pause counter loads GOAL_PAUSE_SECONDS on entry.
    - Decrements on each sec_tick; time_left is frozen.
    - At 0 -> ball_reset pulses for exactly one cycle, then RUNNING.
  - OVER:
    - game_over=1; counts, time_left and winner held.
    - winner computed on entry from the final counts.
    - start=1 -> clears goals, reloads time_left -> RUNNING.
- Widths: counts and time_left are 8-bit unsigned; the tick counter is ceil(log2(CLK_FREQ)) bits.

Decomposition:
- Shared package (quidditch_pkg):
  - State enum IDLE/RUNNING/PAUSE/OVER.
  - Width constants SCORE_W=8, TIME_W=8.
  - Winner encodings WIN_NONE/WIN_T1/WIN_T2.
- One sub-module: sec_tick_gen, parameterised by CLK_FREQ, with inputs clk, rst, enable, clear and output one-cycle tick. The game controller reuses the same divider.

Test Plan (bench sets CLK_FREQ=10, MATCH_SECONDS=5, WIN_SCORE=3, GOAL_PAUSE_SECONDS=2):
- Reset + idle: rst 2 cycles, start=0 for 50 cycles -> goals 0/0, time_left=5, game_over=0, ball_reset never high.
- Timeout: start pulse, game_on=1, no goals -> time_left steps 5..0 every 10 cycles; game_over=1 one cycle after 0; winner=00.
- Held goal + pause: score_to_team1 high for 7 cycles while RUNNING -> team1_goals=1 only; time_left frozen for 20 cycles; exactly one ball_reset pulse, then decrementing resumes.
- Simultaneous goals: both score inputs rise in the same cycle -> goals 1/1, one PAUSE, one ball_reset.
- Win by score: three separated team2 edges -> team2_goals=3, OVER, winner=10, no ball_reset after the third goal; a fourth edge is ignored.
- Reset mid-pause then restart: rst during PAUSE -> IDLE values next cycle. start from OVER -> goals 0/0, time_left=5, RUNNING.

Source files
------------

// File: rtl/quidditch_pkg.sv
// Shared match types: state encoding, display widths and winner codes.
// Used by the scoreboard and the game controller.
package quidditch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSE   = 2'd2,
        OVER    = 2'd3
    } state_e;

    localparam int SCORE_W = 8;
    localparam int TIME_W  = 8;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_T1   = 2'b01,
        WIN_T2   = 2'b10
    } winner_e;

    // A level score is a draw, reported as WIN_NONE.
    function automatic winner_e pick_winner(input logic [SCORE_W-1:0] t1,
                                            input logic [SCORE_W-1:0] t2);
        if (t1 > t2)      return WIN_T1;
        else if (t2 > t1) return WIN_T2;
        else              return WIN_NONE;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds divider: one-cycle tick every CLK_FREQ enabled cycles.
// The count holds while disabled, so a frozen phase resumes where it stopped.
module sec_tick_gen #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/match_scoreboard.sv
// Match scoreboard: goal counting, match clock, post-goal pause and end-of-match decision.
// game_over feeds back to the ball controller; counts and time feed the display.
module match_scoreboard
    import quidditch_pkg::*;
#(
    parameter int CLK_FREQ           = 50000000,
    parameter int MATCH_SECONDS      = 180,
    parameter int WIN_SCORE          = 10,
    parameter int GOAL_PAUSE_SECONDS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               game_on,
    input  logic               score_to_team1,
    input  logic               score_to_team2,
    output logic [SCORE_W-1:0] team1_goals,
    output logic [SCORE_W-1:0] team2_goals,
    output logic [TIME_W-1:0]  time_left,
    output logic               game_over,
    output logic               ball_reset,
    output logic [1:0]         winner
);

    localparam logic [TIME_W-1:0]  MATCH_INIT = TIME_W'(MATCH_SECONDS);
    localparam logic [SCORE_W-1:0] WIN_CNT    = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         PAUSE_INIT = 8'(GOAL_PAUSE_SECONDS);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] t1_q, t1_d, t2_q, t2_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [7:0]         pause_q, pause_d;
    winner_e            winner_q, winner_d;
    logic               ball_reset_q, ball_reset_d;
    logic               s1_q, s2_q;
    logic               edge1, edge2, sec_tick, tick_en, tick_clr;

    assign edge1    = score_to_team1 & ~s1_q;
    assign edge2    = score_to_team2 & ~s2_q;
    assign tick_en  = ((state_q == RUNNING) && game_on) || (state_q == PAUSE);
    assign tick_clr = ((state_q == IDLE) || (state_q == OVER)) && start;

    sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_sec_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (sec_tick)
    );

    always_comb begin
        state_d      = state_q;
        t1_d         = t1_q;
        t2_d         = t2_q;
        time_d       = time_q;
        pause_d      = pause_q;
        winner_d     = winner_q;
        ball_reset_d = 1'b0;
        case (state_q)
            IDLE: begin
                t1_d   = '0;
                t2_d   = '0;
                time_d = MATCH_INIT;
                if (start) begin
                    state_d  = RUNNING;
                    winner_d = WIN_NONE;
                end
            end
            RUNNING: begin
                // A clock already at zero ends the match before any further goal counts.
                if (time_q == '0) begin
                    state_d  = OVER;
                    winner_d = pick_winner(t1_q, t2_q);
                end else begin
                    if (sec_tick)            time_d = time_q - TIME_W'(1);
                    if (edge1 && t1_q != '1) t1_d   = t1_q + SCORE_W'(1);
                    if (edge2 && t2_q != '1) t2_d   = t2_q + SCORE_W'(1);
                    if (t1_d >= WIN_CNT || t2_d >= WIN_CNT) begin
                        state_d  = OVER;
                        winner_d = pick_winner(t1_d, t2_d);
                    end else if (edge1 || edge2) begin
                        state_d = PAUSE;
                        pause_d = PAUSE_INIT;
                    end
                end
            end
            PAUSE: begin
                if (pause_q == '0) begin
                    state_d      = RUNNING;
                    ball_reset_d = 1'b1;
                end else if (sec_tick) begin
                    pause_d = pause_q - 8'd1;
                end
            end
            OVER: begin
                if (start) begin
                    state_d  = RUNNING;
                    t1_d     = '0;
                    t2_d     = '0;
                    time_d   = MATCH_INIT;
                    winner_d = WIN_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            t1_q         <= '0;
            t2_q         <= '0;
            time_q       <= MATCH_INIT;
            pause_q      <= '0;
            winner_q     <= WIN_NONE;
            ball_reset_q <= 1'b0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            t1_q         <= t1_d;
            t2_q         <= t2_d;
            time_q       <= time_d;
            pause_q      <= pause_d;
            winner_q     <= winner_d;
            ball_reset_q <= ball_reset_d;
            s1_q         <= score_to_team1;
            s2_q         <= score_to_team2;
        end
    end

    assign team1_goals = t1_q;
    assign team2_goals = t2_q;
    assign time_left   = time_q;
    assign game_over   = (state_q == OVER);
    assign ball_reset  = ball_reset_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Self-checking bench for match_scoreboard: directed scenarios plus random play,
// every cycle compared against a behavioural match model.
module tb_match_scoreboard;

    localparam int CF = 10;
    localparam int MS = 5;
    localparam int WS = 3;
    localparam int GP = 2;

    logic       clk = 1'b0;
    logic       rst, start, game_on, score_to_team1, score_to_team2;
    logic [7:0] team1_goals, team2_goals, time_left;
    logic       game_over, ball_reset;
    logic [1:0] winner;

    int tests = 0;
    int fails = 0;
    int br_count = 0;

    always #5 clk = ~clk;

    match_scoreboard #(
        .CLK_FREQ(CF), .MATCH_SECONDS(MS), .WIN_SCORE(WS), .GOAL_PAUSE_SECONDS(GP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .game_on(game_on),
        .score_to_team1(score_to_team1), .score_to_team2(score_to_team2),
        .team1_goals(team1_goals), .team2_goals(team2_goals), .time_left(time_left),
        .game_over(game_over), .ball_reset(ball_reset), .winner(winner)
    );

    // Behavioural model of a match: what the referee sees, not how the RTL stores it.
    typedef enum {M_IDLE, M_PLAY, M_FROZEN, M_DONE} m_mode_e;
    m_mode_e m_mode   = M_IDLE;
    int      m_phase  = 0;
    int      m_t1     = 0, m_t2 = 0;
    int      m_time   = MS;
    int      m_pause  = 0;
    int      m_winner = 0;
    int      m_ball   = 0;
    bit      m_prev1  = 0, m_prev2 = 0;

    function automatic int leader(input int a, input int b);
        return (a > b) ? 1 : (b > a) ? 2 : 0;
    endfunction

    task automatic model_edge(input bit r, input bit st, input bit go, input bit a, input bit b);
        bit  counting, tick, g1, g2;
        m_mode_e mode_now;
        counting = (m_mode == M_PLAY && go) || (m_mode == M_FROZEN);
        tick     = counting && (m_phase == CF - 1);
        g1       = a && !m_prev1;
        g2       = b && !m_prev2;
        mode_now = m_mode;
        m_ball   = 0;
        if (r) begin
            m_mode = M_IDLE; m_phase = 0; m_t1 = 0; m_t2 = 0; m_time = MS;
            m_pause = 0; m_winner = 0; m_prev1 = 0; m_prev2 = 0;
            return;
        end
        if ((mode_now == M_IDLE || mode_now == M_DONE) && st) m_phase = 0;
        else if (counting) m_phase = (m_phase + 1) % CF;
        case (mode_now)
            M_IDLE, M_DONE: begin
                if (mode_now == M_IDLE || st) begin
                    m_t1 = 0; m_t2 = 0; m_time = MS;
                end
                if (st) begin
                    m_mode = M_PLAY; m_winner = 0;
                end
            end
            M_PLAY: begin
                if (m_time == 0) begin
                    m_mode = M_DONE; m_winner = leader(m_t1, m_t2);
                end else begin
                    if (tick) m_time--;
                    if (g1) m_t1 = (m_t1 == 255) ? 255 : m_t1 + 1;
                    if (g2) m_t2 = (m_t2 == 255) ? 255 : m_t2 + 1;
                    if (m_t1 >= WS || m_t2 >= WS) begin
                        m_mode = M_DONE; m_winner = leader(m_t1, m_t2);
                    end else if (g1 || g2) begin
                        m_mode = M_FROZEN; m_pause = GP;
                    end
                end
            end
            M_FROZEN: begin
                if (m_pause == 0) begin
                    m_mode = M_PLAY; m_ball = 1;
                end else if (tick) begin
                    m_pause--;
                end
            end
            default: ;
        endcase
        m_prev1 = a;
        m_prev2 = b;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        check("team1_goals", team1_goals, m_t1);
        check("team2_goals", team2_goals, m_t2);
        check("time_left",   time_left,   m_time);
        check("game_over",   game_over,   m_mode == M_DONE);
        check("ball_reset",  ball_reset,  m_ball);
        check("winner",      winner,      m_winner);
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it.
    task automatic step(input bit r, input bit st, input bit go, input bit a, input bit b);
        rst = r; start = st; game_on = go; score_to_team1 = a; score_to_team2 = b;
        @(posedge clk);
        model_edge(r, st, go, a, b);
        #1;
        compare_model();
        if (ball_reset === 1'b1) br_count++;
    endtask

    task automatic reset_and_start(input bit go);
        step(1, 0, 0, 0, 0);
        step(0, 1, go, 0, 0);
    endtask

    initial begin
        int zero_at, over_at, t0, t_at_br;
        bit a_r, b_r;

        // Reset and idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_time_left", time_left, MS);
        br_count = 0;
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 0);
        check("idle_ball_reset_count", br_count, 0);
        check("idle_time_left", time_left, MS);

        // Timeout with no goals
        reset_and_start(1);
        zero_at = -1; over_at = -1;
        for (int i = 0; i < 200 && over_at < 0; i++) begin
            step(0, 0, 1, 0, 0);
            if (time_left === 8'd0 && zero_at < 0) zero_at = i;
            if (game_over === 1'b1) over_at = i;
        end
        check("timeout_zero_cycle", zero_at, MS * CF - 1);
        check("timeout_over_cycle", over_at, MS * CF);
        check("timeout_winner", winner, 0);

        // Held goal and pause
        reset_and_start(1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        t0 = time_left; br_count = 0; t_at_br = -1;
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0);
        for (int i = 0; i < 40 && br_count == 0; i++) begin
            step(0, 0, 1, 0, 0);
            if (br_count == 1) t_at_br = time_left;
        end
        check("held_goal_count", team1_goals, 1);
        check("held_time_frozen", t_at_br, t0);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
        check("held_single_ball_reset", br_count, 1);
        check("held_time_resumes", time_left, t0 - 1);

        // Simultaneous goals
        reset_and_start(1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        br_count = 0;
        for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 1);
        for (int i = 0; i < 30; i++) step(0, 0, 1, 0, 0);
        check("simul_team1", team1_goals, 1);
        check("simul_team2", team2_goals, 1);
        check("simul_ball_reset", br_count, 1);

        // Win by score with the ball out of play, so the match clock never runs
        reset_and_start(0);
        for (int g = 0; g < WS; g++) begin
            if (g == WS - 1) br_count = 0;
            step(0, 0, 0, 0, 1);
            for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0);
        end
        check("win_team2_goals", team2_goals, WS);
        check("win_game_over", game_over, 1);
        check("win_winner", winner, 2);
        check("win_no_ball_reset", br_count, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        check("win_fourth_goal_ignored", team2_goals, WS);

        // Restart from OVER
        step(0, 1, 1, 0, 0);
        check("restart_team2", team2_goals, 0);
        check("restart_time", time_left, MS);
        check("restart_not_over", game_over, 0);

        // Reset in the middle of a pause
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        check("midpause_team1", team1_goals, 0);
        check("midpause_time", time_left, MS);
        check("midpause_ball_reset", ball_reset, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 1, 0, 0);

        // Random play
        a_r = 0; b_r = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 14) == 0) a_r = ~a_r;
            if ($urandom_range(0, 14) == 0) b_r = ~b_r;
            step($urandom_range(0, 399) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) != 0, a_r, b_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
